wb_stage: RTL and testbench
===========================

// Module: wb_stage
// PURPOSE
//  Writeback stage; sits directly downstream of the MEM stage and consumes its
//  MEM/WB pipeline-register outputs (ALU slot result and memory slot result).
//  Owns the architectural register file (single array write port) and the
//  Z/N/C/V flag register, and serves combinational read ports to decode.
//  A same-cycle dual write to distinct registers is serialised through a
//  one-entry deferral buffer, with a stall back-pressure to upstream.
// PARAMETERS
//  DATA_W  32  register / result width
//  NREG    8   architectural registers; AW = $clog2(NREG) = 3
//  NRD     4   decode read ports
// PORTS
//  clk           in   1        clock; all state updates on rising edge
//  reset         in   1        synchronous, active-low reset (asserted when 0)
//  p4_alu_wen    in   1        ALU slot result valid / write request
//  p4_alu_rd     in   AW       ALU slot destination register
//  p4_alu_aluOut in   DATA_W   ALU slot result
//  p4_mem_wen    in   1        memory slot load-result write request
//  p4_mem_rd     in   AW       memory slot destination register
//  p4_mem_out    in   DATA_W   memory slot data, already zero-extended
//  p4_flag_we    in   1        update flag register this bundle
//  p4_flag_z/n/c/v in 1 each   flag values from EX, carried through MEM
//  rd_addr       in   NRD*AW   packed read addresses, port i = [i*AW +: AW]
//  rd_data       out  NRD*DATA_W packed read data, combinational
//  flags         out  4        {z,n,c,v} architectural flags
//  wb_stall      out  1        upstream must hold MEM/WB register this cycle
// BEHAVIOUR
//  - Reset (reset==0 at an edge): all registers 0, flags 4'b0000, buffer empty,
//    wb_stall 0. A buffered write pending at reset is discarded.
//  - Accept: inputs are consumed only when wb_stall==0. While wb_stall==1, all
//    p4_* inputs are ignored (upstream is holding them).
//  - Single write request (wen set on one slot only): write array at the edge.
//    Latency: 1 edge to the array, 0 cycles via write-through.
//  - Both wen, rd equal: mem slot wins (later slot in bundle order).
//    ALU write is dropped. No buffering, no stall.
//  - Both wen, rd differ: ALU written at the edge. Mem {rd,data} captured into
//    the buffer, buf_valid=1.
//  - wb_stall = buf_valid (registered, no combinational path from inputs).
//  - Buffer drain: while buf_valid, the array write port writes the buffer
//    entry and clears buf_valid at the edge, so the stall lasts exactly 1 cycle.
//  - Flags: when accepted and p4_flag_we, flags <= {z,n,c,v} at the edge.
//    Flags are not updated during a stall cycle.
//  - Read port i priority, highest first:
//    (1) the write being performed at the array port this cycle, on address
//        match (drain entry while stalled, else the accepted mem/ALU write);
//    (2) the buffer entry, on address match;
//    (3) array contents.
//    In the distinct-rd dual-write cycle, both the ALU and mem results are
//    visible through write-through.
//  - No reserved zero register: r0 is writable.
//  - Widths: no arithmetic performed. Addresses >= NREG cannot occur for
//    NREG = 2^AW.
// STRUCTURE
//  - Shared package: DATA_W, NREG, AW, and flag bit indices
//    FLAG_Z=3, FLAG_N=2, FLAG_C=1, FLAG_V=0.
//  - Sub-module regfile_1w (NREG x DATA_W, one write port, NRD async reads,
//    synchronous active-low clear). Arbitration, the buffer, bypass muxing and
//    the flag register live in wb_stage.
// TESTING
//  - Reset: drive reset=0 for 2 cycles -> all rd_data=0, flags=0, wb_stall=0.
//  - ALU only: alu_wen, rd=3, 32'hDEADBEEF; rd_addr port0=3 -> rd_data0 shows
//    DEADBEEF in the same cycle; r3 holds it after the edge; wb_stall=0.
//  - Same-rd conflict: alu rd=5 =0x11, mem rd=5 =0x22 -> r5=0x22, wb_stall
//    stays 0.
//  - Distinct-rd conflict: alu rd=1 =0xA, mem rd=2 =0xB -> next cycle r1=0xA,
//    wb_stall=1, port reading r2 returns 0xB. Inputs presented during the stall
//    (alu rd=4 =0xC) are ignored. Cycle after: r2=0xB, stall=0. Re-present
//    rd=4 -> r4=0xC.
//  - Flags: p4_flag_we with z=1,c=1 -> flags=4'b1010. Flag update issued during
//    a stall is ignored.
//  - Reset mid-op: assert reset while buf_valid=1 -> buffer dropped, target
//    register reads 0, wb_stall=0.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage.
// Register file geometry, flag bit positions, write request bundle.
package wb_stage_pkg;

  localparam int DATA_W = 32;
  localparam int NREG   = 8;
  localparam int AW     = $clog2(NREG);
  localparam int NRD    = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef logic [AW-1:0]     reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;

  typedef struct packed {
    logic      we;
    reg_addr_t addr;
    data_t     data;
  } wr_req_t;

  function automatic logic [3:0] pack_flags(
    input logic z,
    input logic n,
    input logic c,
    input logic v
  );
    logic [3:0] f;
    f         = '0;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/wb_stage_if.sv
// MEM/WB bundle into writeback, with the stall back to upstream.
// master = MEM side, slave = writeback stage.
interface wb_stage_if;
  import wb_stage_pkg::*;

  logic      p4_alu_wen;
  reg_addr_t p4_alu_rd;
  data_t     p4_alu_aluOut;
  logic      p4_mem_wen;
  reg_addr_t p4_mem_rd;
  data_t     p4_mem_out;
  logic      p4_flag_we;
  logic      p4_flag_z;
  logic      p4_flag_n;
  logic      p4_flag_c;
  logic      p4_flag_v;
  logic      wb_stall;

  modport master (
    output p4_alu_wen, p4_alu_rd, p4_alu_aluOut,
    output p4_mem_wen, p4_mem_rd, p4_mem_out,
    output p4_flag_we, p4_flag_z, p4_flag_n,
    output p4_flag_c, p4_flag_v,
    input  wb_stall
  );

  modport slave (
    input  p4_alu_wen, p4_alu_rd, p4_alu_aluOut,
    input  p4_mem_wen, p4_mem_rd, p4_mem_out,
    input  p4_flag_we, p4_flag_z, p4_flag_n,
    input  p4_flag_c, p4_flag_v,
    output wb_stall
  );

endinterface

// File: rtl/wb_stage_regfile_1w.sv
// Architectural register array: one write port, NRD async reads.
// Synchronous active-low clear of every entry.
module regfile_1w
  import wb_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  reg_addr_t             wa,
  input  data_t                 wd,
  input  logic [NRD*AW-1:0]     ra,
  output logic [NRD*DATA_W-1:0] rdata
);

  data_t regs_q [NREG];
  data_t regs_d [NREG];

  // Next array contents: single write port
  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  // Array state with synchronous clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++)
        regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  // Asynchronous read ports
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NRD; i++)
      rdata[i*DATA_W +: DATA_W] = regs_q[ra[i*AW +: AW]];
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: write arbitration, deferral buffer, bypass, flags.
// Distinct-rd dual writes spill the mem slot into a 1-entry buffer.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  wb_stage_if.slave             mw,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [3:0]            flags
);

  logic      buf_valid_q, buf_valid_d;
  reg_addr_t buf_rd_q, buf_rd_d;
  data_t     buf_data_q, buf_data_d;
  logic [3:0] flags_q, flags_d;

  logic    accept;
  logic    dual_split;
  wr_req_t wr;
  logic [NRD*DATA_W-1:0] arr_rdata;

  // Arbitrate the single array write port and plan the buffer
  always_comb begin
    accept     = !buf_valid_q;
    dual_split = accept && mw.p4_alu_wen && mw.p4_mem_wen
               && (mw.p4_alu_rd != mw.p4_mem_rd);
    wr = '0;
    if (buf_valid_q) begin
      wr.we   = 1'b1;
      wr.addr = buf_rd_q;
      wr.data = buf_data_q;
    end else if (mw.p4_mem_wen && !dual_split) begin
      wr.we   = 1'b1;
      wr.addr = mw.p4_mem_rd;
      wr.data = mw.p4_mem_out;
    end else if (mw.p4_alu_wen) begin
      wr.we   = 1'b1;
      wr.addr = mw.p4_alu_rd;
      wr.data = mw.p4_alu_aluOut;
    end
    buf_valid_d = dual_split;
    buf_rd_d    = dual_split ? mw.p4_mem_rd  : buf_rd_q;
    buf_data_d  = dual_split ? mw.p4_mem_out : buf_data_q;
    flags_d     = flags_q;
    if (accept && mw.p4_flag_we)
      flags_d = pack_flags(mw.p4_flag_z, mw.p4_flag_n,
                           mw.p4_flag_c, mw.p4_flag_v);
  end

  // Buffer and flag registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_valid_q <= 1'b0;
      buf_rd_q    <= '0;
      buf_data_q  <= '0;
      flags_q     <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_rd_q    <= buf_rd_d;
      buf_data_q  <= buf_data_d;
      flags_q     <= flags_d;
    end
  end

  regfile_1w u_rf (
    .clk   (clk),
    .rst_n (reset),
    .we    (wr.we),
    .wa    (wr.addr),
    .wd    (wr.data),
    .ra    (rd_addr),
    .rdata (arr_rdata)
  );

  // Read ports: live write, then buffered write, then array
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      reg_addr_t a;
      a = rd_addr[i*AW +: AW];
      if (wr.we && a == wr.addr)
        rd_data[i*DATA_W +: DATA_W] = wr.data;
      else if (dual_split && a == mw.p4_mem_rd)
        rd_data[i*DATA_W +: DATA_W] = mw.p4_mem_out;
      else if (buf_valid_q && a == buf_rd_q)
        rd_data[i*DATA_W +: DATA_W] = buf_data_q;
      else
        rd_data[i*DATA_W +: DATA_W] = arr_rdata[i*DATA_W +: DATA_W];
    end
  end

  assign mw.wb_stall = buf_valid_q;
  assign flags       = flags_q;

endmodule

// File: tb/tb_wb_stage.sv
// Directed vector bench for wb_stage.
// Inputs driven after negedge, outputs sampled 1ns before posedge.
module tb_wb_stage;
  import wb_stage_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [3:0]            flags;

  wb_stage_if mw ();

  wb_stage dut (
    .clk     (clk),
    .reset   (reset),
    .mw      (mw),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .flags   (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        aw;
    logic [2:0]  ar;
    logic [31:0] ad;
    logic        mwe;
    logic [2:0]  mr;
    logic [31:0] md;
    logic        fwe;
    logic [3:0]  fv;
    logic [11:0] ra;
    logic [127:0] exp_rd;
    logic [3:0]  exp_fl;
    logic        exp_st;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  vec_t vt [13];

  function automatic logic [11:0] ra4(
    input logic [2:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  function automatic logic [127:0] rd4(
    input logic [31:0] d0, d1, d2, d3);
    return {d3, d2, d1, d0};
  endfunction

  function automatic vec_t mk(
    input logic aw, input logic [2:0] ar, input logic [31:0] ad,
    input logic mwe, input logic [2:0] mr, input logic [31:0] md,
    input logic fwe, input logic [3:0] fv,
    input logic [11:0] ra, input logic [127:0] exp_rd,
    input logic [3:0] exp_fl, input logic exp_st);
    vec_t v;
    v.aw = aw; v.ar = ar; v.ad = ad;
    v.mwe = mwe; v.mr = mr; v.md = md;
    v.fwe = fwe; v.fv = fv; v.ra = ra;
    v.exp_rd = exp_rd; v.exp_fl = exp_fl; v.exp_st = exp_st;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    mw.p4_alu_wen    = v.aw;
    mw.p4_alu_rd     = v.ar;
    mw.p4_alu_aluOut = v.ad;
    mw.p4_mem_wen    = v.mwe;
    mw.p4_mem_rd     = v.mr;
    mw.p4_mem_out    = v.md;
    mw.p4_flag_we    = v.fwe;
    mw.p4_flag_z     = v.fv[3];
    mw.p4_flag_n     = v.fv[2];
    mw.p4_flag_c     = v.fv[1];
    mw.p4_flag_v     = v.fv[0];
    rd_addr          = v.ra;
  endtask

  task automatic check(input string nm, input vec_t v);
    nvec++;
    for (int i = 0; i < NRD; i++) begin
      if (rd_data[i*32 +: 32] !== v.exp_rd[i*32 +: 32]) begin
        $display("FAIL %s rd_data%0d got %h want %h", nm, i,
                 rd_data[i*32 +: 32], v.exp_rd[i*32 +: 32]);
        nerr++;
      end
    end
    if (flags !== v.exp_fl) begin
      $display("FAIL %s flags got %b want %b", nm, flags, v.exp_fl);
      nerr++;
    end
    if (mw.wb_stall !== v.exp_st) begin
      $display("FAIL %s wb_stall got %b want %b", nm,
               mw.wb_stall, v.exp_st);
      nerr++;
    end
  endtask

  task automatic apply(input string nm, input vec_t v);
    @(negedge clk);
    drive(v);
    #4;
    check(nm, v);
  endtask

  vec_t idle;

  initial begin
    idle = mk(0,0,0, 0,0,0, 0,4'h0, ra4(0,1,2,3),
              rd4(0,0,0,0), 4'h0, 0);
    drive(idle);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    apply("reset_hold", idle);
    reset = 1'b1;

    vt[0]  = mk(0,0,0, 0,0,0, 0,4'h0, ra4(0,1,2,3),
                rd4(0,0,0,0), 4'h0, 0);
    vt[1]  = mk(1,3,32'hDEADBEEF, 0,0,0, 0,4'h0, ra4(3,0,0,0),
                rd4(32'hDEADBEEF,0,0,0), 4'h0, 0);
    vt[2]  = mk(0,0,0, 0,0,0, 0,4'h0, ra4(3,5,0,0),
                rd4(32'hDEADBEEF,0,0,0), 4'h0, 0);
    vt[3]  = mk(1,5,32'h11, 1,5,32'h22, 0,4'h0, ra4(5,3,0,0),
                rd4(32'h22,32'hDEADBEEF,0,0), 4'h0, 0);
    vt[4]  = mk(0,0,0, 0,0,0, 0,4'h0, ra4(5,0,0,0),
                rd4(32'h22,0,0,0), 4'h0, 0);
    vt[5]  = mk(1,1,32'hA, 1,2,32'hB, 0,4'h0, ra4(1,2,0,3),
                rd4(32'hA,32'hB,0,32'hDEADBEEF), 4'h0, 0);
    vt[6]  = mk(1,4,32'hC, 0,0,0, 1,4'b1010, ra4(1,2,4,0),
                rd4(32'hA,32'hB,0,0), 4'h0, 1);
    vt[7]  = mk(1,4,32'hC, 0,0,0, 0,4'h0, ra4(1,2,4,0),
                rd4(32'hA,32'hB,32'hC,0), 4'h0, 0);
    vt[8]  = mk(0,0,0, 0,0,0, 1,4'b1010, ra4(4,2,0,0),
                rd4(32'hC,32'hB,0,0), 4'h0, 0);
    vt[9]  = mk(0,0,0, 0,0,0, 0,4'h0, ra4(4,1,5,3),
                rd4(32'hC,32'hA,32'h22,32'hDEADBEEF), 4'b1010, 0);
    vt[10] = mk(0,0,0, 1,0,32'h77, 1,4'b0101, ra4(0,4,0,0),
                rd4(32'h77,32'hC,32'h77,32'h77), 4'b1010, 0);
    vt[11] = mk(0,0,0, 0,0,0, 0,4'h0, ra4(0,7,6,0),
                rd4(32'h77,0,0,32'h77), 4'b0101, 0);
    vt[12] = mk(1,6,32'h66, 1,7,32'h99, 0,4'h0, ra4(6,7,0,2),
                rd4(32'h66,32'h99,32'h77,32'hB), 4'b0101, 0);

    for (int i = 0; i < 13; i++)
      apply($sformatf("vec%0d", i), vt[i]);

    // reset while the r7 deferral is pending
    @(negedge clk);
    drive(mk(0,0,0, 0,0,0, 0,4'h0, ra4(7,6,0,0),
             rd4(0,0,0,0), 4'h0, 0));
    reset = 1'b0;
    #4;
    check("rst_mid_pre", mk(0,0,0, 0,0,0, 0,4'h0, ra4(7,6,0,0),
          rd4(32'h99,32'h66,32'h77,32'h77), 4'b0101, 1));
    @(negedge clk);
    reset = 1'b1;
    #4;
    check("rst_mid_post", mk(0,0,0, 0,0,0, 0,4'h0, ra4(7,6,0,0),
          rd4(0,0,0,0), 4'h0, 0));
    apply("rst_mid_after", mk(0,0,0, 0,0,0, 0,4'h0, ra4(7,6,0,1),
          rd4(0,0,0,0), 4'h0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
